// File: rtl/masked_sbox_layer_seq.sv
// Nibble-serial sequencer driving a two-share masked Skinny-64 S-box across a full state.
// Optional MASKED_SBOX_LAYER_PRNG_EN sources the S-box fresh randomness from an internal LFSR.
module masked_sbox_layer_seq #(
  parameter int          NIBBLES   = 16,
  parameter int          MAX_WAIT  = 15,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] in_s0,
  input  logic [4*NIBBLES-1:0] in_s1,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [4*NIBBLES-1:0] out_s0,
  output logic [4*NIBBLES-1:0] out_s1,
  output logic                 sb_rst,
  output logic [3:0]           sb_X_s0,
  output logic [3:0]           sb_X_s1,
  output logic [15:0]          sb_Fresh,
  input  logic [3:0]           sb_Y_s0,
  input  logic [3:0]           sb_Y_s1,
  input  logic                 sb_Synch,
  input  logic                 seed_load,
  input  logic [31:0]          seed,
  input  logic [15:0]          rnd_in
);
  localparam int SW = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic [SW-1:0]   work_s0_reg, work_s1_reg;
  logic [SW-1:0]   merged_s0, merged_s1;
  logic [15:0]     rnd_word;
  logic            last_nibble;

  // Working state with the S-box result dropped into nibble idx; each share handled separately.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_merge
    assign merged_s0[gi*4 +: 4] = (idx_reg == IW'(gi)) ? sb_Y_s0 : work_s0_reg[gi*4 +: 4];
    assign merged_s1[gi*4 +: 4] = (idx_reg == IW'(gi)) ? sb_Y_s1 : work_s1_reg[gi*4 +: 4];
  end

  assign last_nibble = (idx_reg == IW'(NIBBLES - 1));

`ifdef MASKED_SBOX_LAYER_PRNG_EN
  logic [31:0] lfsr_reg;
  logic [31:0] lfsr_next;
  logic        unused_rnd;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  assign lfsr_next  = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? 32'h8020_0003 : 32'h0);
  assign rnd_word   = lfsr_reg[15:0];
  assign unused_rnd = ^rnd_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (state_reg == IDLE && seed_load && !start) begin
      lfsr_reg <= (seed == 32'h0) ? LFSR_SEED : seed;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end
`else
  logic unused_seed;

  assign rnd_word    = rnd_in;
  assign unused_seed = ^{seed_load, seed};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      work_s0_reg  <= '0;
      work_s1_reg  <= '0;
      out_s0       <= '0;
      out_s1       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      sb_rst       <= 1'b1;
      sb_X_s0      <= '0;
      sb_X_s1      <= '0;
      sb_Fresh     <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_s0_reg <= in_s0;
            work_s1_reg <= in_s1;
            idx_reg     <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          sb_rst       <= 1'b0;
          sb_X_s0      <= work_s0_reg[{idx_reg, 2'b00} +: 4];
          sb_X_s1      <= work_s1_reg[{idx_reg, 2'b00} +: 4];
          sb_Fresh     <= rnd_word;
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (sb_Synch) begin
            work_s0_reg <= merged_s0;
            work_s1_reg <= merged_s1;
            sb_rst      <= 1'b1;
            if (last_nibble) begin
              // Result is published together with the done pulse.
              out_s0    <= merged_s0;
              out_s1    <= merged_s1;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + IW'(1);
              state_reg <= ISSUE;
            end
          end else if (wait_cnt_reg == CW'(MAX_WAIT - 1)) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            sb_rst    <= 1'b1;
            state_reg <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_masked_sbox_layer_seq.sv
// Self-checking bench: behavioural two-share S-box model, table-driven layers, timeout, reset and PRNG cases.
module tb_masked_sbox_layer_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] in_s0, in_s1;
  logic        busy, done, err;
  logic [63:0] out_s0, out_s1;
  logic        sb_rst;
  logic [3:0]  sb_X_s0, sb_X_s1;
  logic [15:0] sb_Fresh;
  logic [3:0]  sb_Y_s0, sb_Y_s1;
  logic        sb_Synch;
  logic        seed_load;
  logic [31:0] seed;
  logic [15:0] rnd_in;

  int total = 0;
  int bad   = 0;

  masked_sbox_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .in_s0(in_s0), .in_s1(in_s1),
    .busy(busy), .done(done), .err(err), .out_s0(out_s0), .out_s1(out_s1),
    .sb_rst(sb_rst), .sb_X_s0(sb_X_s0), .sb_X_s1(sb_X_s1), .sb_Fresh(sb_Fresh),
    .sb_Y_s0(sb_Y_s0), .sb_Y_s1(sb_Y_s1), .sb_Synch(sb_Synch),
    .seed_load(seed_load), .seed(seed), .rnd_in(rnd_in)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hf7e4d583b2a1096c;
    return t[x*4 +: 4];
  endfunction

  function automatic logic [63:0] ref_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = sbox(x[i*4 +: 4]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural S-box: Synch after sb_w cycles out of reset (0 = never); random output mask per nibble.
  int       sb_w     = 3;
  bit       noise_en = 0;
  int       wcnt     = 0;
  logic [3:0] mask_r = 4'h0;
  logic     noise_r  = 1'b0;

  always @(posedge clk) begin
    if (sb_rst) begin
      wcnt    <= 0;
      mask_r  <= 4'($urandom);
      noise_r <= noise_en & 1'($urandom);
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  assign sb_Synch = sb_rst ? noise_r : (sb_w != 0 && wcnt == sb_w - 1);
  assign sb_Y_s0  = sb_rst ? ~mask_r : (sbox(sb_X_s0 ^ sb_X_s1) ^ mask_r);
  assign sb_Y_s1  = mask_r;

  initial forever begin
    @(posedge clk);
    #2 rnd_in = 16'($urandom);
  end

  // Per-nibble monitor: issued shares, fresh word and hold stability during WAIT.
  logic [63:0] cur_s0, cur_s1;
  int          nib        = 0;
  int          stable_bad = 0;
  logic        prev_rst   = 1'b1;
  logic [15:0] rnd_prev   = 16'h0;
  logic [3:0]  hold_x0, hold_x1;
  logic [15:0] hold_f;
  logic [15:0] fresh_log [16];

  always @(negedge clk) begin
    if (!rst && busy && !sb_rst && prev_rst) begin
      if (nib < 16) begin
        chk($sformatf("x_s0_nib%0d", nib), 64'(sb_X_s0), 64'(cur_s0[nib*4 +: 4]));
        chk($sformatf("x_s1_nib%0d", nib), 64'(sb_X_s1), 64'(cur_s1[nib*4 +: 4]));
`ifndef MASKED_SBOX_LAYER_PRNG_EN
        chk($sformatf("fresh_nib%0d", nib), 64'(sb_Fresh), 64'(rnd_prev));
`endif
        fresh_log[nib] = sb_Fresh;
      end else begin
        chk("nibble_overrun", 64'(nib), 64'd15);
      end
      hold_x0 = sb_X_s0;
      hold_x1 = sb_X_s1;
      hold_f  = sb_Fresh;
      nib++;
    end else if (!rst && !sb_rst && !prev_rst) begin
      if (sb_X_s0 !== hold_x0 || sb_X_s1 !== hold_x1 || sb_Fresh !== hold_f) stable_bad++;
    end
    rnd_prev = rnd_in;
    prev_rst = sb_rst;
  end

  // Runs one layer from the current IDLE cycle; reports done latency, done count and exit cycle.
  task automatic run_layer(input logic [63:0] a0, input logic [63:0] a1,
                           output int lat, output int ndone, output int cyc);
    cur_s0 = a0; cur_s1 = a1; nib = 0; stable_bad = 0;
    lat = -1; ndone = 0;
    in_s0 = a0; in_s1 = a1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (busy && cyc < 400) begin
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
      if (cyc == 10) begin start = 1'b1; in_s0 = ~a0; in_s1 = ~a1; end
      if (cyc == 11) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 400) chk("run_bound", 64'(cyc), 64'd0);
  endtask

  typedef struct {
    logic [63:0] s0;
    logic [63:0] s1;
    int          w;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, ndone, cyc;
    rst = 1'b1; start = 1'b0; in_s0 = '0; in_s1 = '0;
    seed_load = 1'b0; seed = '0; rnd_in = '0;

    vecs[0] = '{64'h0123456789abcdef, 64'h0, 3, 64'hc6901a2b385d4e7f};
    vecs[1] = '{64'h0123456789abcdef ^ 64'h5a5aa5a53c3cc3c3, 64'h5a5aa5a53c3cc3c3, 3,
                64'hc6901a2b385d4e7f};
    for (int i = 2; i < 6; i++) begin
      vecs[i].s0  = {$urandom, $urandom};
      vecs[i].s1  = {$urandom, $urandom};
      vecs[i].w   = $urandom_range(1, 5);
      vecs[i].exp = ref_layer(vecs[i].s0 ^ vecs[i].s1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_s0", out_s0, 64'd0);
    chk("rst_out_s1", out_s1, 64'd0);
    chk("rst_sb_rst", 64'(sb_rst), 64'd1);
    chk("rst_sb_x", 64'({sb_X_s0, sb_X_s1}), 64'd0);
    chk("rst_sb_fresh", 64'(sb_Fresh), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef MASKED_SBOX_LAYER_PRNG_EN
    seed = 32'h0; seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
    sb_w = 3; noise_en = 0;
    run_layer(vecs[0].s0, vecs[0].s1, lat, ndone, cyc);
    chk("prng_seed0_fresh", 64'(fresh_log[0]), 64'h0003);
    chk("prng_fresh_differs", 64'(fresh_log[1] != fresh_log[0]), 64'd1);
    chk("prng_layer_result", out_s0 ^ out_s1, vecs[0].exp);
`endif

    for (int i = 0; i < 6; i++) begin
      sb_w = vecs[i].w; noise_en = (i >= 2);
      run_layer(vecs[i].s0, vecs[i].s1, lat, ndone, cyc);
      chk($sformatf("v%0d_result", i), out_s0 ^ out_s1, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(1 + 16 * (1 + vecs[i].w)));
      chk($sformatf("v%0d_done_count", i), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_err", i), 64'(err), 64'd0);
      chk($sformatf("v%0d_x_stable", i), 64'(stable_bad), 64'd0);
      chk($sformatf("v%0d_nibbles", i), 64'(nib), 64'd16);
      $display("layer %0d w=%0d in=%h out=%h latency=%0d", i, vecs[i].w,
               vecs[i].s0 ^ vecs[i].s1, out_s0 ^ out_s1, lat);
    end

    sb_w = 0; noise_en = 0;
    run_layer(vecs[2].s0, vecs[2].s1, lat, ndone, cyc);
    chk("timeout_exit_cycle", 64'(cyc), 64'd17);
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_busy", 64'(busy), 64'd0);
    chk("timeout_no_done", 64'(ndone), 64'd0);
    $display("timeout layer exit_cycle=%0d err=%0d", cyc, err);

    sb_w = 3;
    run_layer(vecs[1].s0, vecs[1].s1, lat, ndone, cyc);
    chk("after_timeout_err", 64'(err), 64'd0);
    chk("after_timeout_result", out_s0 ^ out_s1, vecs[1].exp);
    chk("after_timeout_latency", 64'(lat), 64'd65);

    cur_s0 = vecs[3].s0; cur_s1 = vecs[3].s1; nib = 0;
    in_s0 = vecs[3].s0; in_s1 = vecs[3].s1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300 && nib < 8; k++) begin
      @(posedge clk); #1;
    end
    chk("midrst_reached_nib7", 64'(nib), 64'd8);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sb_rst", 64'(sb_rst), 64'd1);
    chk("midrst_out_s0", out_s0, 64'd0);
    chk("midrst_out_s1", out_s1, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_layer(vecs[0].s0, vecs[0].s1, lat, ndone, cyc);
    chk("midrst_next_result", out_s0 ^ out_s1, vecs[0].exp);
    chk("midrst_next_done_count", 64'(ndone), 64'd1);
    $display("reset-recovery layer out=%h latency=%0d", out_s0 ^ out_s1, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/masked_sbox_layer_seq.md
# masked_sbox_layer_seq

Sequencer that applies the first-order masked Skinny-64 4-bit S-box to a full two-share state, one nibble at a time. It sits directly upstream of the single-nibble GHPC clock-gated S-box. It drives the S-box's share inputs, its 16-bit fresh randomness and its reset. It collects each result on the S-box's `Synch` and returns the substituted two-share state. A timeout watchdog reports an S-box that never synchronises.

## Interface
Parameters:
- `NIBBLES`, 16: nibbles per state; state width is 4*NIBBLES.
- `MAX_WAIT`, 15: maximum cycles in WAIT before timeout.
- `LFSR_SEED`, 32'h0000_0001: reset value of the PRNG. Also used in place of an all-zero seed.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a layer. Sampled only in IDLE.
- `in_s0`, `in_s1` in 4*NIBBLES: input state shares. Captured on an accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the layer has completed.
- `err` out 1: sticky timeout flag. Cleared on reset or on an accepted `start`.
- `out_s0`, `out_s1` out 4*NIBBLES: result state shares.
- `sb_rst` out 1: reset to the S-box instance.
- `sb_X_s0`, `sb_X_s1` out 4: nibble shares driven to the S-box.
- `sb_Fresh` out 16: fresh randomness driven to the S-box.
- `sb_Y_s0`, `sb_Y_s1` in 4: S-box output shares.
- `sb_Synch` in 1: S-box output-valid indication.
- `seed_load` in 1, `seed` in 32: PRNG reseed request. Honoured in IDLE only.
- `rnd_in` in 16: external randomness. Used only without the PRNG macro.

## Operation
- State machine: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE. A timeout sends WAIT -> IDLE.
- IDLE
  - `start`=1: capture `in_s0`/`in_s1` into the working registers; idx=0; clear `err`; go to ISSUE.
  - `seed_load`=1 with `start`=0: load `seed` into the PRNG, or `LFSR_SEED` if `seed`==0.
  - `start` and `seed_load` together: `start` wins and the seed is dropped.
- ISSUE (1 cycle)
  - Drive `sb_rst`=1.
  - Latch nibble idx of both shares into `sb_X_s0`/`sb_X_s1`.
  - Latch the randomness word into `sb_Fresh`.
  - Clear the wait counter; go to WAIT.
- WAIT
  - `sb_rst`=0. `sb_X_*` and `sb_Fresh` are held unchanged.
  - Wait counter increments each cycle.
  - On the first cycle with `sb_Synch`=1, write `sb_Y_s0`/`sb_Y_s1` into nibble idx of the working registers.
  - If idx==NIBBLES-1, go to DONE. Otherwise idx+1 and go to ISSUE.
  - If the counter reaches `MAX_WAIT` with no `sb_Synch`: set `err`, go to IDLE, no `done` pulse. Working-register contents are then unspecified.
- DONE (1 cycle): copy the working registers to `out_s0`/`out_s1`; `done`=1; go to IDLE.
- Nibble order: idx 0 = bits [3:0] first, ascending. Results go back to the same bit positions.
- Shares are never combined inside the block. Every datapath register holds exactly one share.
- PRNG
  - 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
  - Steps once per `clk` cycle while not in reset.
  - Randomness word = LFSR[15:0] at ISSUE.
- `start` while busy: ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `out_s0`=`out_s1`=0, `sb_rst`=1, `sb_X_s0`=`sb_X_s1`=0, `sb_Fresh`=0. State=IDLE, idx=0, LFSR=`LFSR_SEED`.
- `sb_rst` is held high while in IDLE and DONE, so the S-box clock gating stays parked between nibbles.
- Per-nibble cycles = 1 (ISSUE) + W. W is the number of WAIT cycles up to and including the `sb_Synch` cycle.
- Total cycles from accepted `start` to `done` = 1 + NIBBLES*(1+W). With W=3 and NIBBLES=16 this is 65.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- A new `start` is accepted in the cycle immediately after `done`.
- Reset mid-operation: returns to reset values next cycle. No `done`; `out_*` cleared.
- `sb_Synch` high during ISSUE or IDLE: ignored.

## Configuration
- `MASKED_SBOX_LAYER_PRNG_EN`
  - Defined: `sb_Fresh` comes from the internal LFSR. `rnd_in` is ignored.
  - Undefined: the LFSR and the reseed logic are removed. `seed_load`/`seed` are ignored, and `sb_Fresh` latches `rnd_in` at ISSUE.

## Test plan
- Functional mapping: bench uses the team's d1 GHPC clock-gated Skinny S-box, with `in_s0`=64'h0123456789abcdef and `in_s1`=0, then `start`. Required: `out_s0`^`out_s1`=64'hc6901a2b385d4e7f, `err`=0, and exactly one `done`.
- Masked input: `in_s1`=64'h5a5a_a5a5_3c3c_c3c3 and `in_s0`=64'h0123456789abcdef ^ `in_s1`. Required: unmasked result 64'hc6901a2b385d4e7f.
- Timing: behavioural S-box model raises `sb_Synch` 3 cycles after `sb_rst` falls. Required: `done` exactly 65 cycles after the `start` cycle; `sb_X_*` stable throughout every WAIT.
- Timeout: model never asserts `sb_Synch`, `MAX_WAIT`=15. Required: `err`=1 and `busy`=0 16 cycles after the first ISSUE; no `done`; next `start` clears `err`.
- Reset mid-layer: assert `rst` at nibble 7. Required: next cycle `busy`=0, `sb_rst`=1, `out_*`=0; a following `start` completes normally.
- PRNG, macro defined: `seed_load` with `seed`=0 gives LFSR=32'h1. Two consecutive ISSUEs show different `sb_Fresh` values. `rnd_in` has no effect.
